// File: rtl/spi_slave_sync_if.sv
// rtl/spi_slave_sync_if.sv - SPI pin and word-side signal bundle for spi_slave_sync
interface spi_slave_sync_if #(
  parameter int WIDTH = 13
);
  logic             load;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             frame_err;
  logic             busy;
  logic [WIDTH-1:0] sr_stx;
  logic [WIDTH-1:0] sr_srx;

  modport slave (
    input  load, sclk, mosi, din,
    output miso, dout, dout_vld, frame_err, busy, sr_stx, sr_srx
  );

  modport master (
    output load, sclk, mosi, din,
    input  miso, dout, dout_vld, frame_err, busy, sr_stx, sr_srx
  );
endinterface

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - SPI mode-0 slave oversampled in the clk domain
// Pins pass through two-flop synchronisers; a third stage gives edge events.
module spi_slave_sync #(
  parameter int WIDTH = 13
) (
  input logic            clk,
  input logic            rst,
  spi_slave_sync_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [7:0] W8    = 8'(WIDTH);

  logic load_s1_q, load_s2_q, load_d3_q;
  logic sclk_s1_q, sclk_s2_q, sclk_d3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic fe, sr, sf;

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             miso_q, miso_d;
  logic [WIDTH-1:0] stx_q, stx_d;
  logic [WIDTH-1:0] srx_q, srx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [1:0]       flush_q, flush_d;
  logic             armed_q, armed_d;

  assign fe = load_s2_q & ~load_d3_q;
  assign sr = sclk_s2_q & ~sclk_d3_q;
  assign sf = ~sclk_s2_q & sclk_d3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_s1_q <= 1'b1;
      load_s2_q <= 1'b1;
      load_d3_q <= 1'b1;
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d3_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      load_s1_q <= bus.load;
      load_s2_q <= load_s1_q;
      load_d3_q <= load_s2_q;
      sclk_s1_q <= bus.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d3_q <= sclk_s2_q;
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // A frame may only start once load has been seen high after reset, so a
  // load held low across reset release is not mistaken for a fresh frame.
  always_comb begin
    flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    armed_d = armed_q | ((flush_q == 2'd2) & load_s2_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    stx_d   = stx_q;
    srx_d   = srx_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    miso_d  = busy_q ? stx_q[WIDTH-1] : 1'b0;
    case (state_q)
      IDLE: begin
        // Level test on load also catches a fall that arrived during DONE.
        if (armed_q && !load_s2_q) begin
          stx_d   = bus.din;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sr) begin
          srx_d = {srx_q[WIDTH-2:0], mosi_s2_q};
          if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        end
        if (sf) stx_d = {stx_q[WIDTH-2:0], 1'b0};
        if (fe) state_d = DONE;
      end
      DONE: begin
        if (cnt_q == W8) begin
          dout_d = srx_q;
          vld_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      miso_q  <= 1'b0;
      stx_q   <= '0;
      srx_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      flush_q <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      miso_q  <= miso_d;
      stx_q   <= stx_d;
      srx_q   <= srx_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;
  assign bus.sr_stx    = stx_q;
  assign bus.sr_srx    = srx_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - directed and randomized frames against a word-level SPI model
module tb_spi_slave_sync;
  localparam int W = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_sync_if #(.WIDTH(W)) bus ();
  spi_slave_sync #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int exp_vld = 0;
  int exp_err = 0;
  logic [31:0] srx_m  = '0;
  logic [31:0] dout_m = '0;

  always @(negedge clk) begin
    if (bus.dout_vld === 1'b1) vld_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_miso"}, 32'(bus.miso), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_vld"}, 32'(bus.dout_vld), 0);
    chk({tag, "_err"}, 32'(bus.frame_err), 0);
    chk({tag, "_dout"}, 32'(bus.dout), 0);
    chk({tag, "_stx"}, 32'(bus.sr_stx), 0);
    chk({tag, "_srx"}, 32'(bus.sr_srx), 0);
  endtask

  // Master side of one frame: n bits of data MSB first, half-period h clocks.
  task automatic frame(input string tag, input logic [31:0] data, input int n,
                       input int h, input int gap, input logic [W-1:0] dinv);
    logic [31:0] rx;
    logic [31:0] exp_rx;
    rx = '0;
    exp_rx = '0;
    for (int i = 0; i < n; i++)
      exp_rx = (exp_rx << 1) | ((i < W) ? 32'(dinv[W-1-i]) : 32'd0);
    bus.din  = dinv;
    bus.load = 1'b0;
    bus.mosi = data[n-1];
    wait_cyc(h);
    bus.din = W'($urandom);
    for (int i = 0; i < n; i++) begin
      rx = (rx << 1) | 32'(bus.miso);
      bus.sclk = 1'b1;
      wait_cyc(h);
      bus.sclk = 1'b0;
      if (i < n - 1) bus.mosi = data[n-2-i];
      wait_cyc(h);
    end
    chk({tag, "_busy_act"}, 32'(bus.busy), 1);
    chk({tag, "_miso_word"}, rx, exp_rx);
    bus.load = 1'b1;
    srx_m = ((srx_m << n) | data) & 32'h1fff;
    if (n == W) begin
      dout_m = data & 32'h1fff;
      exp_vld++;
    end else begin
      exp_err++;
    end
    wait_cyc(gap);
  endtask

  task automatic check_result(input string tag);
    wait_cyc(8);
    chk({tag, "_vld_cnt"}, 32'(vld_cnt), 32'(exp_vld));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_dout"}, 32'(bus.dout), dout_m);
    chk({tag, "_srx"}, 32'(bus.sr_srx), srx_m);
    chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
    chk({tag, "_miso_idle"}, 32'(bus.miso), 0);
  endtask

  initial begin
    int n;
    int h;
    logic [31:0] d;
    bus.load = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.din  = '0;
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(6);

    frame("basic", 32'h1dad, 13, 9, 0, 13'h0ced);
    check_result("basic");

    frame("b2b_a", 32'h0001, 13, 7, 3, 13'h1234);
    frame("b2b_b", 32'h1fff, 13, 7, 0, 13'h0abc);
    check_result("b2b");

    frame("short", 32'h0a5a, 12, 6, 0, 13'h1555);
    check_result("short");

    frame("long", 32'h3dad, 14, 6, 0, 13'h1b3c);
    check_result("long");

    // Reset in the middle of a frame, released with load still low.
    bus.din  = 13'h1f0f;
    bus.load = 1'b0;
    wait_cyc(7);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'($urandom);
      bus.sclk = 1'b1;
      wait_cyc(7);
      bus.sclk = 1'b0;
      wait_cyc(7);
    end
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    srx_m  = '0;
    dout_m = '0;
    wait_cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.sclk = 1'b1;
      wait_cyc(7);
      bus.sclk = 1'b0;
      wait_cyc(7);
    end
    chk("midrst_busy_after", 32'(bus.busy), 0);
    chk("midrst_vld_cnt", 32'(vld_cnt), 32'(exp_vld));
    chk("midrst_err_cnt", 32'(err_cnt), 32'(exp_err));
    bus.load = 1'b1;
    wait_cyc(6);
    frame("postrst", 32'h0f3c, 13, 8, 0, 13'h16e9);
    check_result("postrst");

    // sclk activity with load high must be ignored.
    for (int i = 0; i < 4; i++) begin
      bus.mosi = 1'($urandom);
      bus.sclk = 1'b1;
      wait_cyc(6);
      chk("idle_sclk_busy", 32'(bus.busy), 0);
      chk("idle_sclk_miso", 32'(bus.miso), 0);
      bus.sclk = 1'b0;
      wait_cyc(6);
    end
    check_result("idle_sclk");

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(11, 15);
      h = $urandom_range(6, 9);
      d = $urandom & ((32'd1 << n) - 1);
      frame("rand", d, n, h, 0, W'($urandom));
      check_result("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
